// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map constants and decode type shared by the memory responder
package mem_map_pkg;
  localparam int DEFAULT_ADDR_WIDTH = 17;
  localparam logic [31:0] IO_TX_ADDR = 32'h30000;
  localparam logic [31:0] IO_STAT_ADDR = 32'h30004;
  localparam logic [1:0] IO_REGION_SEL = 2'b11;
  typedef enum logic [1:0] {SEL_RAM, SEL_TX, SEL_STAT, SEL_NONE} io_sel_e;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: byte-serial memory bus between controller (master) and responder (slave)
//   mem_a    : byte address
//   mem_wr   : write strobe for mem_dout
//   mem_dout : write data from controller
//   mem_din  : registered read data for the previous cycle's address
interface mem_responder_if;
  logic [31:0] mem_a;
  logic mem_wr;
  logic [7:0] mem_dout;
  logic [7:0] mem_din;
  modport master(output mem_a, mem_wr, mem_dout, input mem_din);
  modport slave(input mem_a, mem_wr, mem_dout, output mem_din);
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO with stall gating
//   clk_in/rst_in/rdy_in : clock, sync active-low reset, stall (low freezes state)
//   push/push_data       : enqueue request; dropped when full unless a pop frees a slot
//   pop                  : dequeue request; ignored when empty
//   head                 : oldest entry
//   count/full/empty     : occupancy
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  // on an empty FIFO a same-cycle pop is suppressed, so the push wins
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk_in)
    if (rdy_in && do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: byte-serial bus responder serving block RAM plus UART TX/RX FIFOs in the IO region
//   clk_in/rst_in/rdy_in : clock, sync active-low reset, global stall (low freezes all state)
//   bus                  : controller byte bus (mem_a, mem_wr, mem_dout, mem_din)
//   io_buffer_full       : TX FIFO has at most one free entry
//   tx_data/valid/ready  : TX FIFO head toward the serializer
//   rx_data/valid/ready  : bytes from the deserializer into the RX FIFO
//   program_finished     : sticky halt flag, set by a write to IO_STAT_ADDR
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int    FIFO_DEPTH = 16,
  parameter string INIT_FILE  = ""
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  mem_responder_if.slave    bus,
  output logic              io_buffer_full,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              program_finished
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [7:0] ram [2**ADDR_WIDTH];
  io_sel_e sel;
  logic [7:0] rd_byte, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic seen, last_wr, fresh;
  logic [31:0] last_a;
  always_comb
    sel = bus.mem_a[17:16] != IO_REGION_SEL ? SEL_RAM
        : bus.mem_a == IO_TX_ADDR ? SEL_TX
        : bus.mem_a == IO_STAT_ADDR ? SEL_STAT : SEL_NONE;
  // RX pops only on the first cycle of an access so an idling controller consumes one byte
  assign fresh = !seen || last_wr || bus.mem_a != last_a;
  always_comb
    rd_byte = sel == SEL_RAM ? ram[bus.mem_a[ADDR_WIDTH-1:0]]
            : sel == SEL_TX && !rx_empty ? rx_head
            : sel == SEL_STAT ? {7'b0, rx_count != '0} : 8'h00;
  // one free slot of margin for the push the controller may issue after its idle check
  assign io_buffer_full = tx_full || tx_count == CW'(FIFO_DEPTH - 1);
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  always_ff @(posedge clk_in)
    if (rdy_in && bus.mem_wr && sel == SEL_RAM) ram[bus.mem_a[ADDR_WIDTH-1:0]] <= bus.mem_dout;
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      bus.mem_din <= '0;
      seen <= 1'b0;
      last_a <= '0;
      last_wr <= 1'b0;
      program_finished <= 1'b0;
    end else if (rdy_in) begin
      bus.mem_din <= rd_byte;
      seen <= 1'b1;
      last_a <= bus.mem_a;
      last_wr <= bus.mem_wr;
      if (bus.mem_wr && sel == SEL_STAT) program_finished <= 1'b1;
    end
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .push(bus.mem_wr && sel == SEL_TX), .push_data(bus.mem_dout),
    .pop(tx_valid && tx_ready), .head(tx_data),
    .count(tx_count), .full(tx_full), .empty(tx_empty)
  );
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .push(rx_valid && rx_ready), .push_data(rx_data),
    .pop(!bus.mem_wr && sel == SEL_TX && fresh), .head(rx_head),
    .count(rx_count), .full(rx_full), .empty(rx_empty)
  );
endmodule
